alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_if.sv | 28 ++
 rtl/alu_pipe.sv | 146 ++++++++++++++
 tb/tb_alu_pipe.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Handshake and payload bundle for alu_pipe.
// The slave side is the ALU; the master side is the producer/consumer pair.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dataOut;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic [15:0]      ovf_count;

  modport slave (
    input  in_valid, dataA, dataB, sel, out_ready,
    output in_ready, out_valid, dataOut, cout, overflow, zero, ovf_count
  );

  modport master (
    output in_valid, dataA, dataB, sel, out_ready,
    input  in_ready, out_valid, dataOut, cout, overflow, zero, ovf_count
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 holds operands, S2 holds the computed result.
// Counts delivered overflowing results, saturating at 16'hFFFF.
module alu_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  alu_pipe_if.slave  bus
);
  localparam int unsigned MSB  = WIDTH - 1;
  localparam int unsigned SUMW = WIDTH + 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [2:0] OP_NOR = 3'b100;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       sel_q, sel_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [15:0]      ovf_cnt_q, ovf_cnt_d;

  logic             s2_adv_c;
  logic             in_ready_c;
  logic             accept_c;
  logic             deliver_c;
  logic             binv_c;
  logic [WIDTH-1:0] b_mod_c;
  logic [WIDTH:0]   sum_c;
  logic             ovf_int_c;
  logic [WIDTH-1:0] res_c;
  logic             cout_c;
  logic             ovf_c;

  // ADD/SUB/SLT share one adder; binv turns it into A + ~B + 1
  always_comb begin
    binv_c    = (sel_q == OP_SUB) || (sel_q == OP_SLT);
    b_mod_c   = b_q ^ {WIDTH{binv_c}};
    sum_c     = {1'b0, a_q} + {1'b0, b_mod_c} + SUMW'(binv_c);
    ovf_int_c = (a_q[MSB] == b_mod_c[MSB]) && (sum_c[MSB] != a_q[MSB]);
    res_c     = '0;
    cout_c    = 1'b0;
    ovf_c     = 1'b0;
    case (sel_q)
      OP_AND: res_c = a_q & b_q;
      OP_OR:  res_c = a_q | b_q;
      OP_NOR: res_c = ~(a_q | b_q);
      OP_ADD, OP_SUB: begin
        res_c  = sum_c[MSB:0];
        cout_c = sum_c[WIDTH];
        ovf_c  = ovf_int_c;
      end
      OP_SLT: begin
        // sign of the true difference, corrected for overflow
        res_c[0] = sum_c[MSB] ^ ovf_int_c;
        cout_c   = sum_c[WIDTH];
      end
      default: ;
    endcase
  end

  // Handshake and next-state
  always_comb begin
    s2_adv_c   = !s2_valid_q || bus.out_ready;
    in_ready_c = !s1_valid_q || s2_adv_c;
    accept_c   = bus.in_valid && in_ready_c;
    deliver_c  = s2_valid_q && bus.out_ready;

    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    ovf_cnt_d  = ovf_cnt_q;

    if (in_ready_c) begin
      s1_valid_d = bus.in_valid;
      if (accept_c) begin
        a_d   = bus.dataA;
        b_d   = bus.dataB;
        sel_d = bus.sel;
      end
    end

    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d  = res_c;
        cout_d = cout_c;
        ovf_d  = ovf_c;
        zero_d = (res_c == '0);
      end
    end

    if (deliver_c && ovf_q && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sel_q      <= sel_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = s2_valid_q;
  assign bus.dataOut   = res_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.ovf_count = ovf_cnt_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: WIDTH=32 and WIDTH=8 instances on a shared clock/reset.
module tb_alu_pipe;
  logic clk;
  logic rst;

  alu_pipe_if #(.WIDTH(32)) bus32 ();
  alu_pipe_if #(.WIDTH(8))  bus8 ();

  alu_pipe #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus32));
  alu_pipe #(.WIDTH(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt;

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus32.in_valid = 1'b1; bus32.dataA = 32'd1; bus32.dataB = 32'd1; bus32.sel = 3'b010;
    bus8.in_valid  = 1'b1; bus8.dataA  = 8'd1;  bus8.dataB  = 8'd1;  bus8.sel  = 3'b010;
    tick(); tick();
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus32.out_valid); end
    checks++; if (bus32.dataOut !== 32'h0) begin errors++; $display("FAIL reset_dataOut: got %h expected 0", bus32.dataOut); end
    checks++; if (bus32.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", bus32.cout); end
    checks++; if (bus32.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus32.overflow); end
    checks++; if (bus32.zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", bus32.zero); end
    checks++; if (bus32.ovf_count !== 16'h0) begin errors++; $display("FAIL reset_ovf_count: got %h expected 0", bus32.ovf_count); end
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL reset8_out_valid: got %b expected 0", bus8.out_valid); end
    rst = 1'b0;
    bus32.in_valid = 1'b0;
    bus8.in_valid  = 1'b0;
    #1;
    checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus32.in_ready); end
    tick(); tick();
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_accept: got out_valid %b expected 0", bus32.out_valid); end
    exp_cnt = 16'h0;
  endtask

  task automatic test_ops();
    vec_t v[14];
    v[0]  = '{3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    v[1]  = '{3'b110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1};
    v[2]  = '{3'b111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0};
    v[3]  = '{3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    v[4]  = '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
    v[5]  = '{3'b001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0};
    v[6]  = '{3'b100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    v[7]  = '{3'b100, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    v[8]  = '{3'b011, 32'h00001234, 32'h00005678, 32'h00000000, 1'b0, 1'b0, 1'b1};
    v[9]  = '{3'b110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    v[10] = '{3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    v[11] = '{3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    v[12] = '{3'b111, 32'h00000003, 32'h00000005, 32'h00000001, 1'b0, 1'b0, 1'b0};
    v[13] = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1};
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      bus32.in_valid = 1'b1; bus32.sel = v[i].sel; bus32.dataA = v[i].a; bus32.dataB = v[i].b;
      tick();
      bus32.in_valid = 1'b0;
      checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL op%0d_latency: got out_valid %b expected 0", i, bus32.out_valid); end
      tick();
      checks++; if (bus32.out_valid !== 1'b1) begin errors++; $display("FAIL op%0d_out_valid: got %b expected 1", i, bus32.out_valid); end
      checks++; if (bus32.dataOut !== v[i].r) begin errors++; $display("FAIL op%0d_dataOut: got %h expected %h", i, bus32.dataOut, v[i].r); end
      checks++; if (bus32.cout !== v[i].c) begin errors++; $display("FAIL op%0d_cout: got %b expected %b", i, bus32.cout, v[i].c); end
      checks++; if (bus32.overflow !== v[i].o) begin errors++; $display("FAIL op%0d_overflow: got %b expected %b", i, bus32.overflow, v[i].o); end
      checks++; if (bus32.zero !== v[i].z) begin errors++; $display("FAIL op%0d_zero: got %b expected %b", i, bus32.zero, v[i].z); end
      if (v[i].o) exp_cnt = exp_cnt + 16'd1;
      tick();
      checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL op%0d_drained: got out_valid %b expected 0", i, bus32.out_valid); end
      checks++; if (bus32.ovf_count !== exp_cnt) begin errors++; $display("FAIL op%0d_ovf_count: got %0d expected %0d", i, bus32.ovf_count, exp_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea[4];
    logic [31:0] eb[4];
    logic [31:0] er[4];
    int tx = 0;
    int rx = 0;
    logic acc;
    logic dlv;
    ea[0] = 32'd1;   eb[0] = 32'd2;   er[0] = 32'd3;
    ea[1] = 32'd10;  eb[1] = 32'd20;  er[1] = 32'd30;
    ea[2] = 32'd100; eb[2] = 32'd200; er[2] = 32'd300;
    ea[3] = 32'h7FFFFFFF; eb[3] = 32'h7FFFFFFF; er[3] = 32'hFFFFFFFE;
    for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
      bus32.out_ready = (cyc >= 5);
      if (tx < 4) begin
        bus32.in_valid = 1'b1; bus32.sel = 3'b010; bus32.dataA = ea[tx]; bus32.dataB = eb[tx];
      end else begin
        bus32.in_valid = 1'b0;
      end
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready c%0d: got %b expected 0", cyc, bus32.in_ready); end
        checks++; if (tx != 2) begin errors++; $display("FAIL b2b_accepted c%0d: got %0d expected 2", cyc, tx); end
        checks++; if (bus32.out_valid !== 1'b1 || bus32.dataOut !== er[0]) begin errors++; $display("FAIL b2b_stable c%0d: got v=%b d=%h expected v=1 d=%h", cyc, bus32.out_valid, bus32.dataOut, er[0]); end
      end
      acc = bus32.in_valid && bus32.in_ready;
      dlv = bus32.out_valid && bus32.out_ready;
      if (dlv) begin
        checks++; if (bus32.dataOut !== er[rx]) begin errors++; $display("FAIL b2b_result%0d: got %h expected %h", rx, bus32.dataOut, er[rx]); end
        rx++;
      end
      tick();
      if (acc) tx++;
    end
    bus32.in_valid = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    #1;
    checks++; if (rx != 4) begin errors++; $display("FAIL b2b_delivered: got %0d expected 4", rx); end
    checks++; if (tx != 4) begin errors++; $display("FAIL b2b_accepted_total: got %0d expected 4", tx); end
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_duplicate: got out_valid %b expected 0", bus32.out_valid); end
    checks++; if (bus32.ovf_count !== exp_cnt) begin errors++; $display("FAIL b2b_ovf_count: got %0d expected %0d", bus32.ovf_count, exp_cnt); end
  endtask

  task automatic test_stall_ovf();
    bus32.out_ready = 1'b0;
    bus32.in_valid = 1'b1; bus32.sel = 3'b010; bus32.dataA = 32'h7FFFFFFF; bus32.dataB = 32'h00000001;
    tick();
    bus32.in_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus32.out_valid !== 1'b1 || bus32.overflow !== 1'b1 || bus32.dataOut !== 32'h80000000) begin errors++; $display("FAIL stall_hold%0d: got v=%b o=%b d=%h expected v=1 o=1 d=80000000", k, bus32.out_valid, bus32.overflow, bus32.dataOut); end
      checks++; if (bus32.ovf_count !== exp_cnt) begin errors++; $display("FAIL stall_count%0d: got %0d expected %0d", k, bus32.ovf_count, exp_cnt); end
      tick();
    end
    bus32.out_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (bus32.ovf_count !== exp_cnt) begin errors++; $display("FAIL stall_release_count: got %0d expected %0d", bus32.ovf_count, exp_cnt); end
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %b expected 0", bus32.out_valid); end
    tick(); tick();
    checks++; if (bus32.ovf_count !== exp_cnt) begin errors++; $display("FAIL stall_once: got %0d expected %0d", bus32.ovf_count, exp_cnt); end
  endtask

  task automatic test_reset_midflight();
    bus32.out_ready = 1'b0;
    bus32.in_valid = 1'b1; bus32.sel = 3'b010; bus32.dataA = 32'd1; bus32.dataB = 32'd1;
    tick();
    bus32.dataA = 32'd2; bus32.dataB = 32'd2;
    tick();
    bus32.dataA = 32'd3; bus32.dataB = 32'd3;
    #1;
    checks++; if (bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b1) begin errors++; $display("FAIL mid_full: got rdy=%b v=%b expected rdy=0 v=1", bus32.in_ready, bus32.out_valid); end
    checks++; if (bus32.ovf_count !== exp_cnt) begin errors++; $display("FAIL mid_pre_count: got %0d expected %0d", bus32.ovf_count, exp_cnt); end
    bus32.out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus32.in_valid = 1'b0;
    exp_cnt = 16'h0;
    #1;
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", bus32.out_valid); end
    checks++; if (bus32.ovf_count !== 16'h0) begin errors++; $display("FAIL mid_ovf_count: got %0d expected 0", bus32.ovf_count); end
    checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", bus32.in_ready); end
    checks++; if (bus32.dataOut !== 32'h0) begin errors++; $display("FAIL mid_dataOut: got %h expected 0", bus32.dataOut); end
    tick(); tick();
    checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL mid_discarded: got out_valid %b expected 0", bus32.out_valid); end
    bus32.in_valid = 1'b1; bus32.sel = 3'b011; bus32.dataA = 32'hDEADBEEF; bus32.dataB = 32'h00000001;
    tick();
    bus32.in_valid = 1'b0;
    tick();
    checks++; if (bus32.out_valid !== 1'b1 || bus32.dataOut !== 32'h0 || bus32.zero !== 1'b1) begin errors++; $display("FAIL mid_reserved: got v=%b d=%h z=%b expected v=1 d=0 z=1", bus32.out_valid, bus32.dataOut, bus32.zero); end
    tick();
  endtask

  task automatic test_width8();
    logic [2:0] s8[4];
    logic [7:0] a8[4];
    logic [7:0] b8[4];
    logic [7:0] r8[4];
    logic [2:0] f8[4];
    s8[0] = 3'b010; a8[0] = 8'hFF; b8[0] = 8'h01; r8[0] = 8'h00; f8[0] = 3'b101;
    s8[1] = 3'b010; a8[1] = 8'h7F; b8[1] = 8'h01; r8[1] = 8'h80; f8[1] = 3'b010;
    s8[2] = 3'b111; a8[2] = 8'h80; b8[2] = 8'h01; r8[2] = 8'h01; f8[2] = 3'b100;
    s8[3] = 3'b110; a8[3] = 8'h10; b8[3] = 8'h20; r8[3] = 8'hF0; f8[3] = 3'b000;
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus8.in_valid = 1'b1; bus8.sel = s8[i]; bus8.dataA = a8[i]; bus8.dataB = b8[i];
      tick();
      bus8.in_valid = 1'b0;
      tick();
      checks++; if (bus8.out_valid !== 1'b1 || bus8.dataOut !== r8[i]) begin errors++; $display("FAIL w8_op%0d_data: got v=%b d=%h expected v=1 d=%h", i, bus8.out_valid, bus8.dataOut, r8[i]); end
      checks++; if ({bus8.cout, bus8.overflow, bus8.zero} !== f8[i]) begin errors++; $display("FAIL w8_op%0d_flags: got c/o/z=%b expected %b", i, {bus8.cout, bus8.overflow, bus8.zero}, f8[i]); end
      tick();
    end
    checks++; if (bus8.ovf_count !== 16'd1) begin errors++; $display("FAIL w8_ovf_count: got %0d expected 1", bus8.ovf_count); end
  endtask

  initial begin
    rst = 1'b1;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.dataA = '0; bus32.dataB = '0; bus32.sel = '0;
    bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b0; bus8.dataA  = '0; bus8.dataB  = '0; bus8.sel  = '0;
    exp_cnt = 16'h0;
    test_reset();
    test_ops();
    test_back_to_back();
    test_stall_ovf();
    test_reset_midflight();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
